// File: rtl/serial_uart.sv
// 8N1 UART with TX/RX FIFOs and sticky overrun/framing flags for the MMIO serial window.
// Defining SERIAL_UART_LOOPBACK_EN adds internal TX->RX loopback selected by loopback_in.
module serial_uart #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TX_DEPTH     = 16,
    parameter int RX_DEPTH     = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data_in,
    input  logic       tx_wren_in,
    output logic       tx_ready_out,
    output logic [7:0] rx_data_out,
    output logic       rx_valid_out,
    input  logic       rx_rden_in,
    input  logic       uart_rx_in,
    output logic       uart_tx_out,
    input  logic       clear_err_in,
    output logic       overrun_out,
    output logic       frame_err_out,
    input  logic       loopback_in
);
    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int TPW = $clog2(TX_DEPTH);
    localparam int RPW = $clog2(RX_DEPTH);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TPW:0]  TX_FULL   = (TPW + 1)'(TX_DEPTH);
    localparam logic [RPW:0]  RX_FULL   = (RPW + 1)'(RX_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic [7:0]    r_txMem [TX_DEPTH];
    logic [TPW-1:0] r_txWrPtr, r_txRdPtr;
    logic [TPW:0]  r_txCount, w_txCountNext;
    logic          r_txReady, w_txPush, w_txPop;
    state_e        r_txState;
    logic [CW-1:0] r_txCnt;
    logic [2:0]    r_txIdx;
    logic [7:0]    r_txShift;
    logic          r_txLine;

    logic [7:0]    r_rxMem [RX_DEPTH];
    logic [RPW-1:0] r_rxWrPtr, r_rxRdPtr, w_rxRdNext;
    logic [RPW:0]  r_rxCount, w_rxCountNext;
    logic          r_rxValid, w_rxPush, w_rxPop, w_rxDrop;
    logic [7:0]    r_rxData, w_rxHeadNext;
    logic          r_overrun;
    logic          r_sync1, r_sync2, r_rxPrev, w_rxSource;
    state_e        r_rxState;
    logic [CW-1:0] r_rxCnt;
    logic [2:0]    r_rxIdx;
    logic [7:0]    r_rxShift;
    logic          r_rxPushValid;
    logic [7:0]    r_rxPushData;
    logic          r_frameErr;

`ifdef SERIAL_UART_LOOPBACK_EN
    assign w_rxSource  = loopback_in ? r_txLine : uart_rx_in;
    assign uart_tx_out = loopback_in ? 1'b1 : r_txLine;
`else
    logic w_unusedLoopback;
    assign w_unusedLoopback = loopback_in;
    assign w_rxSource  = uart_rx_in;
    assign uart_tx_out = r_txLine;
`endif

    assign tx_ready_out  = r_txReady;
    assign rx_valid_out  = r_rxValid;
    assign rx_data_out   = r_rxData;
    assign overrun_out   = r_overrun;
    assign frame_err_out = r_frameErr;

    assign w_txPush = tx_wren_in & r_txReady;
    assign w_txPop  = (r_txState == IDLE) && (r_txCount != '0);

    always_comb begin
        w_txCountNext = r_txCount;
        case ({w_txPush, w_txPop})
            2'b10:   w_txCountNext = r_txCount + (TPW + 1)'(1);
            2'b01:   w_txCountNext = r_txCount - (TPW + 1)'(1);
            default: w_txCountNext = r_txCount;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_txPush) r_txMem[r_txWrPtr] <= tx_data_in;
    end

    // Ready is registered from the post-update count so a full FIFO never takes an extra byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_txWrPtr <= '0;
            r_txRdPtr <= '0;
            r_txCount <= '0;
            r_txReady <= 1'b1;
        end else begin
            if (w_txPush) r_txWrPtr <= r_txWrPtr + TPW'(1);
            if (w_txPop)  r_txRdPtr <= r_txRdPtr + TPW'(1);
            r_txCount <= w_txCountNext;
            r_txReady <= (w_txCountNext != TX_FULL);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_txState <= IDLE;
            r_txCnt   <= '0;
            r_txIdx   <= '0;
            r_txShift <= '0;
            r_txLine  <= 1'b1;
        end else begin
            case (r_txState)
                IDLE: begin
                    r_txLine <= 1'b1;
                    r_txCnt  <= '0;
                    if (w_txPop) begin
                        r_txShift <= r_txMem[r_txRdPtr];
                        r_txLine  <= 1'b0;
                        r_txState <= START;
                    end
                end
                START: begin
                    if (r_txCnt == BIT_LAST) begin
                        r_txCnt   <= '0;
                        r_txIdx   <= '0;
                        r_txLine  <= r_txShift[0];
                        r_txState <= DATA;
                    end else begin
                        r_txCnt <= r_txCnt + CW'(1);
                    end
                end
                DATA: begin
                    if (r_txCnt == BIT_LAST) begin
                        r_txCnt <= '0;
                        if (r_txIdx == 3'd7) begin
                            r_txLine  <= 1'b1;
                            r_txState <= STOP;
                        end else begin
                            r_txIdx   <= r_txIdx + 3'd1;
                            r_txShift <= {1'b0, r_txShift[7:1]};
                            r_txLine  <= r_txShift[1];
                        end
                    end else begin
                        r_txCnt <= r_txCnt + CW'(1);
                    end
                end
                STOP: begin
                    if (r_txCnt == BIT_LAST) begin
                        r_txCnt   <= '0;
                        r_txState <= IDLE;
                    end else begin
                        r_txCnt <= r_txCnt + CW'(1);
                    end
                end
                default: r_txState <= IDLE;
            endcase
        end
    end

    // r_rxPrev lets IDLE react only to a genuine 1->0 edge, not to a line held low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_rxPrev <= 1'b1;
        end else begin
            r_sync1  <= w_rxSource;
            r_sync2  <= r_sync1;
            r_rxPrev <= r_sync2;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rxState     <= IDLE;
            r_rxCnt       <= '0;
            r_rxIdx       <= '0;
            r_rxShift     <= '0;
            r_rxPushValid <= 1'b0;
            r_rxPushData  <= '0;
            r_frameErr    <= 1'b0;
        end else begin
            r_rxPushValid <= 1'b0;
            if (clear_err_in) r_frameErr <= 1'b0;
            case (r_rxState)
                IDLE: begin
                    r_rxCnt <= '0;
                    if (r_rxPrev && !r_sync2) r_rxState <= START;
                end
                START: begin
                    if (r_rxCnt == HALF_LAST) begin
                        r_rxCnt   <= '0;
                        r_rxIdx   <= '0;
                        r_rxState <= r_sync2 ? IDLE : DATA;
                    end else begin
                        r_rxCnt <= r_rxCnt + CW'(1);
                    end
                end
                DATA: begin
                    if (r_rxCnt == BIT_LAST) begin
                        r_rxCnt   <= '0;
                        r_rxShift <= {r_sync2, r_rxShift[7:1]};
                        if (r_rxIdx == 3'd7) r_rxState <= STOP;
                        else                 r_rxIdx   <= r_rxIdx + 3'd1;
                    end else begin
                        r_rxCnt <= r_rxCnt + CW'(1);
                    end
                end
                STOP: begin
                    if (r_rxCnt == BIT_LAST) begin
                        r_rxCnt   <= '0;
                        r_rxState <= IDLE;
                        if (r_sync2) begin
                            r_rxPushValid <= 1'b1;
                            r_rxPushData  <= r_rxShift;
                        end else begin
                            r_frameErr <= 1'b1;
                        end
                    end else begin
                        r_rxCnt <= r_rxCnt + CW'(1);
                    end
                end
                default: r_rxState <= IDLE;
            endcase
        end
    end

    assign w_rxPush = r_rxPushValid && (r_rxCount != RX_FULL);
    assign w_rxDrop = r_rxPushValid && (r_rxCount == RX_FULL);
    assign w_rxPop  = rx_rden_in && r_rxValid;

    // The head register is preloaded with next cycle's head, bypassing a byte written this cycle.
    always_comb begin
        w_rxCountNext = r_rxCount;
        case ({w_rxPush, w_rxPop})
            2'b10:   w_rxCountNext = r_rxCount + (RPW + 1)'(1);
            2'b01:   w_rxCountNext = r_rxCount - (RPW + 1)'(1);
            default: w_rxCountNext = r_rxCount;
        endcase
        w_rxRdNext   = w_rxPop ? r_rxRdPtr + RPW'(1) : r_rxRdPtr;
        w_rxHeadNext = r_rxData;
        if (w_rxCountNext != '0) begin
            w_rxHeadNext = (w_rxPush && (r_rxWrPtr == w_rxRdNext)) ? r_rxPushData
                                                                   : r_rxMem[w_rxRdNext];
        end
    end

    always_ff @(posedge clock) begin
        if (w_rxPush) r_rxMem[r_rxWrPtr] <= r_rxPushData;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rxWrPtr <= '0;
            r_rxRdPtr <= '0;
            r_rxCount <= '0;
            r_rxValid <= 1'b0;
            r_rxData  <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_rxPush) r_rxWrPtr <= r_rxWrPtr + RPW'(1);
            r_rxRdPtr <= w_rxRdNext;
            r_rxCount <= w_rxCountNext;
            r_rxValid <= (w_rxCountNext != '0);
            r_rxData  <= w_rxHeadNext;
            if (clear_err_in) r_overrun <= 1'b0;
            if (w_rxDrop)     r_overrun <= 1'b1;
        end
    end
endmodule

// File: doc/serial_uart.md
Name: serial_uart

Overview:
- Physical serial port behind the data memory's serial MMIO window.
- Consumes the byte/write-strobe/read-strobe outputs of the MMIO buffer and produces its byte/ready/valid inputs.
- Serialises TX bytes to an 8N1 UART line and deserialises the RX line into bytes.
- TX and RX each have a small FIFO so software polling does not lose characters.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 4
TX_DEPTH, 16, TX FIFO entries; power of two, >= 2
RX_DEPTH, 16, RX FIFO entries; power of two, >= 2

Ports:
clock  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
tx_data_in  input  8  byte to transmit (from MMIO serial_out)
tx_wren_in  input  1  push tx_data_in into TX FIFO this cycle
tx_ready_out  output  1  TX FIFO not full (to MMIO serial_ready_in)
rx_data_out  output  8  head of RX FIFO, show-ahead (to MMIO serial_in)
rx_valid_out  output  1  RX FIFO not empty (to MMIO serial_valid_in)
rx_rden_in  input  1  pop RX FIFO head this cycle
uart_rx_in  input  1  asynchronous serial line in, idle high
uart_tx_out  output  1  serial line out, idle high
clear_err_in  input  1  clears sticky error flags
overrun_out  output  1  sticky: RX byte dropped, FIFO full
frame_err_out  output  1  sticky: stop bit sampled low
loopback_in  input  1  loopback select (used only with optional feature)

Behaviour:
- Reset (async assert, sync deassert externally):
  - FIFOs empty; both FSMs IDLE.
  - uart_tx_out=1, tx_ready_out=1, rx_valid_out=0, rx_data_out=0, overrun_out=0, frame_err_out=0.
  - Reset mid-frame aborts the frame; TX line returns high immediately.
- TX FIFO:
  - tx_wren_in with tx_ready_out=1 pushes; entry visible to TX FSM next cycle.
  - tx_wren_in while full: byte silently dropped, no state change.
  - Push and FSM pop in the same cycle are both honoured; count unchanged.
  - tx_ready_out is registered-quality, derived from the count after the current cycle's updates.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: line=1; if FIFO not empty, pop and load shifter -> START.
  - START: line=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: 8 bits LSB first, CLKS_PER_BIT each; 3-bit index counts 0..7 -> STOP.
  - STOP: line=1 for CLKS_PER_BIT cycles -> IDLE.
  - Latency: byte pushed in cycle N -> start bit on uart_tx_out from cycle N+2 when idle.
  - Back-to-back bytes: next start bit immediately follows the stop bit (IDLE lasts 1 cycle).
- RX path:
  - uart_rx_in passes a 2-flop synchroniser before use.
  - RX FSM states IDLE, START, DATA, STOP.
  - IDLE: synchronised line falling 1->0 -> START, counter cleared.
  - START: at CLKS_PER_BIT/2 resample; low -> DATA; high -> glitch, back to IDLE, nothing recorded.
  - DATA: sample every CLKS_PER_BIT from the mid-bit point, shift LSB first, 8 samples -> STOP.
  - STOP: sample at mid stop bit, then -> IDLE.
    - Sample high: push byte.
    - Sample low: discard byte, set frame_err_out.
  - Push while RX FIFO full: byte dropped, set overrun_out; existing contents untouched.
- RX FIFO:
  - rx_data_out always shows the head entry; holds last value when empty.
  - rx_rden_in with rx_valid_out=1 pops; new head visible next cycle.
  - rx_rden_in when empty is ignored.
  - Simultaneous push and pop are both honoured.
- Sticky flags:
  - Set by events above; cleared only by clear_err_in or reset.
  - clear_err_in and a set event in the same cycle: set wins.
- Counters: bit-time counter width clog2(CLKS_PER_BIT); FIFO pointers wrap modulo depth; count is one bit wider than the pointers.

Optional Feature:
- Macro: SERIAL_UART_LOOPBACK_EN.
- Defined:
  - loopback_in=1 feeds the internal TX serial bit into the RX synchroniser input instead of uart_rx_in.
  - uart_tx_out is forced to 1 (idle) while loopback_in=1.
  - Switching loopback_in mid-frame may corrupt that frame only.
- Not defined: loopback_in is ignored, RX always uses uart_rx_in, and no loopback logic is synthesised.

Test Plan:
- CLKS_PER_BIT=4, push 0xA5 -> uart_tx_out: start 0, bits 1,0,1,0,0,1,0,1, stop 1, each 4 cycles; start bit begins 2 cycles after the push.
- Push 17 bytes 0x00..0x10 with TX idle-blocked (TX_DEPTH=16, bytes written faster than transmitted) -> tx_ready_out drops once full, later pushes dropped; line sequence shows no skipped or duplicated bytes among those accepted.
- Drive RX frame 0x3C at CLKS_PER_BIT=4 -> rx_valid_out=1, rx_data_out=0x3C; pulse rx_rden_in -> rx_valid_out=0 next cycle.
- Drive RX frame with stop bit 0 -> no push, frame_err_out=1; pulse clear_err_in -> 0.
- Drive 17 RX frames with no reads (RX_DEPTH=16) -> 16 bytes held in order, overrun_out=1; 2-cycle low glitch on idle line -> no byte.
- Assert reset mid TX DATA and mid RX DATA -> uart_tx_out=1 immediately; FIFOs empty; all flags 0.
